instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ENTRYPOINT, default 32'h0000_1000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSN, default 32'h0000_0013, the instruction output value when no instruction is held.
REQ-003 The block SHALL have port clk  in  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port jump_flag  in  1  redirect request from the execute stage.
REQ-006 The block SHALL have port jump_address  in  32  redirect target from the execute stage.
REQ-007 The block SHALL have port imem_req  out  1  instruction-memory request valid.
REQ-008 The block SHALL have port imem_addr  out  32  instruction-memory request address.
REQ-009 The block SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-010 The block SHALL have port imem_rvalid  in  1  read data valid, at least one cycle after acceptance.
REQ-011 The block SHALL have port imem_rdata  in  32  read data.
REQ-012 The block SHALL have port instruction  out  32  held instruction to decode.
REQ-013 The block SHALL have port instruction_address  out  32  PC of the held instruction.
REQ-014 The block SHALL have port instruction_valid  out  1  instruction/instruction_address are meaningful.
REQ-015 The block SHALL have port consume  in  1  downstream takes the held instruction this cycle.

Function
REQ-016 The block SHALL implement states FETCH, WAIT and HOLD, with at most one memory request outstanding.
REQ-017 In FETCH: imem_req=1 and imem_addr=req_addr, where req_addr is a register loaded from pc on entry to FETCH. On imem_ready the block SHALL move to WAIT.
REQ-018 While imem_req=1 and imem_ready=0, imem_addr SHALL remain stable, even across a jump.
REQ-019 In WAIT: imem_req=0. On imem_rvalid with discard=0, the block SHALL register instruction<=imem_rdata, instruction_address<=req_addr and instruction_valid<=1, set pc<=req_addr+4, and move to HOLD.
REQ-020 In HOLD: instruction_valid=1 and no request is issued. On consume the block SHALL clear instruction_valid, set instruction<=NOP_INSN, and move to FETCH (request issued the following cycle, req_addr=pc).
REQ-021 Jump target SHALL be {jump_address[31:1],1'b0}; jump_flag has priority over consume and over rvalid in the same cycle.
REQ-022 Jump in HOLD: pc<=target, instruction_valid<=0, instruction<=NOP_INSN, move to FETCH.
REQ-023 Jump in FETCH (with or without imem_ready): pc<=target and discard<=1. The in-flight or pending request completes normally.
REQ-024 Jump in WAIT: pc<=target and discard<=1. If imem_rvalid occurs in the same cycle, the data SHALL be dropped, discard cleared, and the block SHALL go to FETCH.
REQ-025 imem_rvalid in WAIT with discard=1 SHALL be dropped: discard<=0, go to FETCH with req_addr=pc (the target). pc is not incremented.
REQ-026 imem_rvalid outside WAIT SHALL be ignored.
REQ-027 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-028 Fetch-to-fetch latency with zero-wait memory (ready in cycle of req, rvalid next cycle) and consume held high SHALL be 3 cycles per instruction.

Reset
REQ-029 While rst=1 the block SHALL hold: state=FETCH, pc=req_addr=ENTRYPOINT, discard=0, imem_req=0, instruction=NOP_INSN, instruction_address=ENTRYPOINT, instruction_valid=0.
REQ-030 imem_req SHALL first assert in the first cycle after rst deasserts, with imem_addr=ENTRYPOINT.
REQ-031 Reset asserted mid-transaction SHALL abandon the request. Any later imem_rvalid SHALL be ignored until a new request is accepted.

Verification
REQ-032 Reset release, zero-wait memory returning 32'h00500093, consume=1 -> imem_addr=32'h1000, then instruction_valid=1 with instruction=32'h00500093 and instruction_address=32'h1000, then next imem_addr=32'h1004.
REQ-033 imem_ready held low for 5 cycles -> imem_req and imem_addr=32'h1000 stable for all 5 cycles, no state change.
REQ-034 In HOLD with consume=0 for 4 cycles -> outputs stable and no request. Then jump_flag=1 with jump_address=32'h2001 -> instruction_valid drops and next imem_addr=32'h2000.
REQ-035 Jump to 32'h3000 while in WAIT; rvalid arrives 2 cycles later with 32'hDEADBEEF -> data never appears on instruction, and next imem_addr=32'h3000.
REQ-036 jump_flag, consume and imem_rvalid asserted in the same cycle -> jump wins, instruction_valid=0, and the next request is to the target.
REQ-037 ENTRYPOINT=32'hFFFF_FFFC -> second request address is 32'h0000_0000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps the program counter and issues one instruction-memory
// request at a time. It holds the returned word for decode until it is consumed, and
// redirects on jumps from execute.
//
// Ports:
//   clk, rst            - rising-edge clock; asynchronous active-high reset
//   jump_flag           - redirect request from execute (wins over consume and rvalid)
//   jump_address        - redirect target; bit 0 is forced to zero
//   imem_req/imem_addr  - request valid and address to instruction memory
//   imem_ready          - memory accepts the request this cycle
//   imem_rvalid         - read data valid (only meaningful while a request is outstanding)
//   imem_rdata          - read data
//   instruction         - held instruction (NOP_INSN when nothing is held)
//   instruction_address - PC of the held instruction
//   instruction_valid   - instruction/instruction_address are meaningful
//   consume             - downstream takes the held instruction this cycle
module instruction_fetch #(
    parameter logic [31:0] ENTRYPOINT = 32'h0000_1000,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [31:0] jump_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instruction_address,
    output logic        instruction_valid,
    input  logic        consume
);

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        discard_q, discard_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] insn_addr_q, insn_addr_d;
    logic        insn_valid_q, insn_valid_d;
    logic [31:0] jump_target;

    // Targets are halfword aligned; bit 0 is always cleared.
    assign jump_target = jump_address & ~32'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        discard_d    = discard_q;
        insn_d       = insn_q;
        insn_addr_d  = insn_addr_q;
        insn_valid_d = insn_valid_q;

        unique case (state_q)
            StFetch: begin
                // req_addr is left alone so imem_addr stays stable while the request is
                // pending; the redirect takes effect once this request has returned.
                if (jump_flag) begin
                    pc_d      = jump_target;
                    discard_d = 1'b1;
                end
                if (imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (jump_flag) begin
                    pc_d = jump_target;
                    if (imem_rvalid) begin
                        // Stale data arriving with the jump is dropped immediately.
                        discard_d  = 1'b0;
                        req_addr_d = jump_target;
                        state_d    = StFetch;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        discard_d  = 1'b0;
                        req_addr_d = pc_q;
                        state_d    = StFetch;
                    end else begin
                        insn_d       = imem_rdata;
                        insn_addr_d  = req_addr_q;
                        insn_valid_d = 1'b1;
                        pc_d         = req_addr_q + 32'd4;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (jump_flag) begin
                    pc_d         = jump_target;
                    req_addr_d   = jump_target;
                    insn_valid_d = 1'b0;
                    insn_d       = NOP_INSN;
                    state_d      = StFetch;
                end else if (consume) begin
                    req_addr_d   = pc_q;
                    insn_valid_d = 1'b0;
                    insn_d       = NOP_INSN;
                    state_d      = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= ENTRYPOINT;
            req_addr_q   <= ENTRYPOINT;
            discard_q    <= 1'b0;
            insn_q       <= NOP_INSN;
            insn_addr_q  <= ENTRYPOINT;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            discard_q    <= discard_d;
            insn_q       <= insn_d;
            insn_addr_q  <= insn_addr_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    // The request is masked during reset so nothing is issued while rst is high.
    assign imem_req            = (state_q == StFetch) && !rst;
    assign imem_addr           = req_addr_q;
    assign instruction         = insn_q;
    assign instruction_address = insn_addr_q;
    assign instruction_valid   = insn_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model and a memory model
// whose contents are a fixed function of the address.
module tb_instruction_fetch;

    localparam logic [31:0] Entry  = 32'h0000_1000;
    localparam logic [31:0] Entry2 = 32'hFFFF_FFFC;
    localparam logic [31:0] Nop    = 32'h0000_0013;
    localparam int PhOpen = 0;  // request visible on the bus, not yet accepted
    localparam int PhOut  = 1;  // request accepted, data not yet returned
    localparam int PhHold = 2;  // instruction held for decode

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instruction_address;
    logic        instruction_valid;
    logic        consume;

    logic        d2_imem_req;
    logic [31:0] d2_imem_addr;
    logic [31:0] d2_instruction;
    logic [31:0] d2_instruction_address;
    logic        d2_instruction_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          phase;
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    logic [31:0] m_iaddr;
    logic        m_stale;

    // Memory model state
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic        mem_rand;

    always #5 clk = ~clk;

    instruction_fetch #(.ENTRYPOINT(Entry), .NOP_INSN(Nop)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .jump_flag           (jump_flag),
        .jump_address        (jump_address),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .instruction         (instruction),
        .instruction_address (instruction_address),
        .instruction_valid   (instruction_valid),
        .consume             (consume)
    );

    // Second instance only used to observe PC wrap-around near the top of memory.
    instruction_fetch #(.ENTRYPOINT(Entry2), .NOP_INSN(Nop)) dut2 (
        .clk                 (clk),
        .rst                 (rst),
        .jump_flag           (jump_flag),
        .jump_address        (jump_address),
        .imem_req            (d2_imem_req),
        .imem_addr           (d2_imem_addr),
        .imem_ready          (imem_ready),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .instruction         (d2_instruction),
        .instruction_address (d2_instruction_address),
        .instruction_valid   (d2_instruction_valid),
        .consume             (consume)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase      = PhOpen;
        m_pc       = Entry;
        m_req_addr = Entry;
        m_iaddr    = Entry;
        m_stale    = 1'b0;
    endtask

    task automatic check_outputs();
        logic exp_req;
        exp_req = (phase == PhOpen) && !rst;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_req_addr);
        chk("instruction_valid", 32'(instruction_valid), 32'(phase == PhHold));
        chk("instruction", instruction, (phase == PhHold) ? mem_word(m_iaddr) : Nop);
        chk("instruction_address", instruction_address, m_iaddr);
    endtask

    // One clock edge of the fetch contract, from the inputs currently applied.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {jump_address[31:1], 1'b0};
        if (phase == PhOpen) begin
            if (jump_flag) begin
                m_pc    = tgt;
                m_stale = 1'b1;
            end
            if (imem_ready) phase = PhOut;
        end else if (phase == PhOut) begin
            if (jump_flag) begin
                m_pc = tgt;
                if (imem_rvalid) begin
                    m_stale    = 1'b0;
                    m_req_addr = tgt;
                    phase      = PhOpen;
                end else begin
                    m_stale = 1'b1;
                end
            end else if (imem_rvalid) begin
                if (m_stale) begin
                    m_stale    = 1'b0;
                    m_req_addr = m_pc;
                    phase      = PhOpen;
                end else begin
                    m_iaddr = m_req_addr;
                    m_pc    = m_req_addr + 32'd4;
                    phase   = PhHold;
                end
            end
        end else begin
            if (jump_flag) begin
                m_pc       = tgt;
                m_req_addr = tgt;
                phase      = PhOpen;
            end else if (consume) begin
                m_req_addr = m_pc;
                phase      = PhOpen;
            end
        end
    endtask

    task automatic mem_step();
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (imem_req && imem_ready) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check, advance.
    task automatic tick(input logic rdy, input logic jf, input logic [31:0] ja,
                        input logic cons, input logic stray);
        imem_ready   = rdy;
        jump_flag    = jf;
        jump_address = ja;
        consume      = cons;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
        end else begin
            imem_rvalid = stray && !mem_busy;
            imem_rdata  = $urandom;
        end
        #1;
        if (rst) model_reset();
        check_outputs();
        if (!rst) model_step();
        mem_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst          = 1'b1;
        jump_flag    = 1'b0;
        jump_address = '0;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        consume      = 1'b0;
        mem_busy     = 1'b0;
        mem_cnt      = 0;
        mem_addr     = '0;
        mem_lat      = 0;
        mem_rand     = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, then zero-wait fetch of the first instruction with consume high.
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_iaddr", instruction_address, Entry);
        rst = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0000_1000);
        chk("wrap_first_addr", d2_imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("first_valid", 32'(instruction_valid), 32'd1);
        chk("first_insn", instruction, 32'h0050_0093);
        chk("first_iaddr", instruction_address, 32'h0000_1000);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("second_addr", imem_addr, 32'h0000_1004);
        chk("wrap_second_addr", d2_imem_addr, 32'h0000_0000);

        // Memory stalls the request for five cycles.
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h0000_1000);
            tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Held instruction stays put without consume, then a jump to an odd address.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("hold_valid", 32'(instruction_valid), 32'd1);
        tick(1'b0, 1'b1, 32'h0000_2001, 1'b0, 1'b0);
        chk("jump_hold_valid", 32'(instruction_valid), 32'd0);
        chk("jump_hold_addr", imem_addr, 32'h0000_2000);

        // Jump while waiting; the stale word arrives two cycles later and is dropped.
        mem_lat = 2;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("drop_insn", instruction, Nop);
        chk("drop_req", 32'(imem_req), 32'd1);
        chk("drop_addr", imem_addr, 32'h0000_3000);

        // Jump, consume and rvalid in one cycle: the jump wins.
        mem_lat = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
        chk("prio_valid", 32'(instruction_valid), 32'd0);
        chk("prio_addr", imem_addr, 32'h0000_4000);

        // Reset in mid-transaction; the late response must be ignored.
        mem_lat = 3;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        guard = 0;
        while (mem_busy && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            guard++;
        end
        chk("late_rvalid_drained", 32'(mem_busy), 32'd0);
        chk("late_rvalid_valid", 32'(instruction_valid), 32'd0);
        chk("late_rvalid_addr", imem_addr, Entry);
        mem_lat = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("after_reset_valid", 32'(instruction_valid), 32'd1);
        chk("after_reset_iaddr", instruction_address, Entry);

        // Randomized traffic.
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        r_rdy;
            logic [31:0] r_ja;
            rst   = ($urandom_range(0, 299) == 0);
            r_rdy = !mem_busy && ($urandom_range(0, 2) != 0);
            r_ja  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : $urandom;
            tick(r_rdy, $urandom_range(0, 7) == 0, r_ja, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
